// File: rtl/pce_rom_loader.sv
// pce_rom_loader: turns the HPS ROM download stream (16-bit ioctl words)
// into toggle-handshake writes on the DDRAM ROM write port.
//
// Ports:
//   clk_sys, reset         system clock, synchronous active-high reset
//   ioctl_download         download window from hps_io
//   ioctl_wr, ioctl_dout   word strobe and data (low byte = lower address)
//   ioctl_wait             back-pressure to hps_io (registered)
//   swap                   reverse bit order inside each byte of a word
//   wr_addr, wr_data       current write (byte address, always even)
//   wr_req / wr_ack        toggle handshake; pending while they differ
//   rom_size               bytes written in the last/current download
//   hdr_present            rom_size has a 512-byte copier header
//   done_flag              download finished, results valid
//   err_overrun            sticky: a word arrived while a write was pending
module pce_rom_loader #(
    parameter int AW      = 24,
    parameter int HDR_BIT = 9
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [15:0]   ioctl_dout,
    output logic          ioctl_wait,
    input  logic          swap,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          wr_req,
    input  logic          wr_ack,
    output logic [AW-1:0] rom_size,
    output logic          hdr_present,
    output logic          done_flag,
    output logic          err_overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PEND,
        DRAIN,
        DONE
    } state_t;

    state_t        state, state_n;
    logic          dl_q;
    logic          wait_n;
    logic          req_n;
    logic [AW-1:0] addr_n;
    logic [15:0]   data_n;
    logic [AW-1:0] size_n;
    logic          done_n;
    logic          err_n;
    logic          dl_rise;
    logic          acked;

    function automatic logic [15:0] rev_bytes(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = d[7-i];
            r[8+i]   = d[15-i];
        end
        return r;
    endfunction

    assign dl_rise     = ioctl_download & ~dl_q;
    assign acked       = (wr_req == wr_ack);
    assign hdr_present = rom_size[HDR_BIT];

    always_comb begin
        state_n = state;
        wait_n  = ioctl_wait;
        req_n   = wr_req;
        addr_n  = wr_addr;
        data_n  = wr_data;
        size_n  = rom_size;
        done_n  = done_flag;
        err_n   = err_overrun;
        unique case (state)
            IDLE, DONE: begin
                if (dl_rise) begin
                    state_n = ARM;
                    addr_n  = '0;
                    size_n  = '0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                end
            end
            ARM: begin
                if (!ioctl_download) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (ioctl_wr) begin
                    data_n  = swap ? rev_bytes(ioctl_dout) : ioctl_dout;
                    req_n   = ~wr_req;
                    wait_n  = 1'b1;
                    state_n = PEND;
                end
            end
            PEND, DRAIN: begin
                // A word offered while the previous one is still in flight
                // is lost, even on the cycle the ack arrives.
                if (ioctl_wr) begin
                    err_n = 1'b1;
                end
                if (acked) begin
                    wait_n = 1'b0;
                    addr_n = wr_addr + AW'(2);
                    size_n = rom_size + AW'(2);
                    if (state == DRAIN || !ioctl_download) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ARM;
                    end
                end else if (!ioctl_download) begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            dl_q        <= 1'b0;
            ioctl_wait  <= 1'b0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rom_size    <= '0;
            done_flag   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_n;
            dl_q        <= ioctl_download;
            ioctl_wait  <= wait_n;
            wr_req      <= req_n;
            wr_addr     <= addr_n;
            wr_data     <= data_n;
            rom_size    <= size_n;
            done_flag   <= done_n;
            err_overrun <= err_n;
        end
    end

endmodule

// File: tb/tb_pce_rom_loader.sv
// tb_pce_rom_loader: directed vector table plus hand-written
// sequences for the handshake corner cases of pce_rom_loader.
module tb_pce_rom_loader;

    localparam int AW = 24;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [15:0]   ioctl_dout;
    logic          ioctl_wait;
    logic          swap;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] rom_size;
    logic          hdr_present;
    logic          done_flag;
    logic          err_overrun;

    int checks = 0;
    int errors = 0;

    logic ack_en;
    int   ack_delay;
    int   ack_cnt;

    always #5 clk_sys = ~clk_sys;

    pce_rom_loader #(.AW(AW), .HDR_BIT(9)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .swap           (swap),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_req         (wr_req),
        .wr_ack         (wr_ack),
        .rom_size       (rom_size),
        .hdr_present    (hdr_present),
        .done_flag      (done_flag),
        .err_overrun    (err_overrun)
    );

    // DDRAM model: acknowledges ack_delay clocks after it sees a request.
    always @(posedge clk_sys) begin
        if (reset) begin
            wr_ack  <= 1'b0;
            ack_cnt <= 0;
        end else if (ack_en && wr_req != wr_ack) begin
            if (ack_cnt >= ack_delay - 1) begin
                wr_ack  <= wr_req;
                ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    typedef struct {
        logic [15:0]   dout;
        logic          sw;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          last;
        logic [AW-1:0] size;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (ioctl_wait && n < max) begin
            tick();
            n++;
        end
        chk("wait_timeout", {31'b0, ioctl_wait}, 32'h0);
    endtask

    task automatic send(input logic [15:0] w, input logic sw);
        ioctl_dout = w;
        swap       = sw;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            send(i[15:0], 1'b0);
            wait_ready(20);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic req0;
        logic dl_on;

        vt[0] = '{16'h1234, 1'b0, 24'h0, 16'h1234, 1'b0, 24'h0};
        vt[1] = '{16'h5678, 1'b0, 24'h2, 16'h5678, 1'b0, 24'h0};
        vt[2] = '{16'h9ABC, 1'b0, 24'h4, 16'h9ABC, 1'b0, 24'h0};
        vt[3] = '{16'hDEF0, 1'b0, 24'h6, 16'hDEF0, 1'b1, 24'h8};
        vt[4] = '{16'h0180, 1'b1, 24'h0, 16'h8001, 1'b0, 24'h0};
        vt[5] = '{16'h12F0, 1'b1, 24'h2, 16'h480F, 1'b1, 24'h4};

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 16'h0;
        swap           = 1'b0;
        ack_en         = 1'b1;
        ack_delay      = 3;
        repeat (3) tick();

        chk("rst_wait", {31'b0, ioctl_wait}, 0);
        chk("rst_req", {31'b0, wr_req}, 0);
        chk("rst_addr", {8'b0, wr_addr}, 0);
        chk("rst_data", {16'b0, wr_data}, 0);
        chk("rst_size", {8'b0, rom_size}, 0);
        chk("rst_done", {31'b0, done_flag}, 0);
        chk("rst_err", {31'b0, err_overrun}, 0);
        reset = 1'b0;
        tick();

        // Vector table: plain words, then a swapped download.
        dl_on = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!dl_on) begin
                start_dl();
                dl_on = 1'b1;
            end
            send(vt[i].dout, vt[i].sw);
            chk("vec_addr", {8'b0, wr_addr}, {8'b0, vt[i].addr});
            chk("vec_data", {16'b0, wr_data}, {16'b0, vt[i].data});
            chk("vec_pend", {31'b0, wr_req != wr_ack}, 1);
            chk("vec_wait", {31'b0, ioctl_wait}, 1);
            chk("vec_done_low", {31'b0, done_flag}, 0);
            wait_ready(20);
            if (vt[i].last) begin
                end_dl();
                dl_on = 1'b0;
                chk("vec_size", {8'b0, rom_size}, {8'b0, vt[i].size});
                chk("vec_done", {31'b0, done_flag}, 1);
                chk("vec_hdr", {31'b0, hdr_present}, 0);
                chk("vec_err", {31'b0, err_overrun}, 0);
            end
        end

        // Header detection on large images.
        ack_delay = 1;
        start_dl();
        burst(32'h2100);
        end_dl();
        chk("hdr_size", {8'b0, rom_size}, 32'h4200);
        chk("hdr_set", {31'b0, hdr_present}, 1);
        start_dl();
        burst(32'h2000);
        end_dl();
        chk("nohdr_size", {8'b0, rom_size}, 32'h4000);
        chk("nohdr_clr", {31'b0, hdr_present}, 0);

        // Overrun: second strobe while the first write is unacked.
        ack_en = 1'b0;
        start_dl();
        chk("ovr_done_clr", {31'b0, done_flag}, 0);
        send(16'h1111, 1'b0);
        req0 = wr_req;
        send(16'h2222, 1'b0);
        chk("ovr_err", {31'b0, err_overrun}, 1);
        chk("ovr_one_toggle", {31'b0, wr_req}, {31'b0, req0});
        chk("ovr_data", {16'b0, wr_data}, 32'h1111);
        chk("ovr_wait", {31'b0, ioctl_wait}, 1);
        ack_en = 1'b1;
        wait_ready(20);
        chk("ovr_size", {8'b0, rom_size}, 2);
        chk("ovr_addr", {8'b0, wr_addr}, 2);
        end_dl();
        chk("ovr_err_sticky", {31'b0, err_overrun}, 1);

        // Download drops while a write is pending; ack 10 clk later.
        ack_delay = 10;
        start_dl();
        chk("drn_err_clr", {31'b0, err_overrun}, 0);
        send(16'hAAAA, 1'b0);
        ioctl_download = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("drn_done_hold", {31'b0, done_flag}, 0);
            chk("drn_wait_hold", {31'b0, ioctl_wait}, 1);
        end
        tick();
        chk("drn_acked", {31'b0, wr_ack == wr_req}, 1);
        chk("drn_done_late", {31'b0, done_flag}, 0);
        tick();
        chk("drn_done", {31'b0, done_flag}, 1);
        chk("drn_size", {8'b0, rom_size}, 2);
        chk("drn_wait", {31'b0, ioctl_wait}, 0);

        // Reset in the middle of a handshake.
        ack_delay = 3;
        start_dl();
        send(16'h3333, 1'b0);
        wait_ready(20);
        ack_en = 1'b0;
        send(16'h4444, 1'b0);
        chk("rmid_pend", {31'b0, wr_req != wr_ack}, 1);
        chk("rmid_addr", {8'b0, wr_addr}, 2);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        chk("rmid_req", {31'b0, wr_req}, 0);
        chk("rmid_wait", {31'b0, ioctl_wait}, 0);
        chk("rmid_addr0", {8'b0, wr_addr}, 0);
        chk("rmid_done", {31'b0, done_flag}, 0);
        chk("rmid_size", {8'b0, rom_size}, 0);
        reset  = 1'b0;
        ack_en = 1'b1;
        tick();
        start_dl();
        send(16'h5555, 1'b0);
        chk("rnew_addr", {8'b0, wr_addr}, 0);
        chk("rnew_data", {16'b0, wr_data}, 32'h5555);
        wait_ready(20);
        end_dl();
        chk("rnew_size", {8'b0, rom_size}, 2);
        chk("rnew_done", {31'b0, done_flag}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
